// File: rtl/sevseg_pkg.sv
// Shared types and constants for the seven-segment display controller.
package sevseg_pkg;

  typedef logic [3:0] hex_nibble_t;
  typedef logic [6:0] seg_t;  // gfedcba, active-low

  localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/sevseg_scan_ctrl_hex2sevseg.sv
// Common-anode hex-to-seven-segment decoder (gfedcba, active-low).
module hex2sevseg
  import sevseg_pkg::*;
(
  input  hex_nibble_t nibble_i,
  output seg_t        seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// Multiplexed N-digit seven-segment scanner with frame-synchronous value
// swap, anti-ghost blanking, leading-zero suppression and registered pins.
module sevseg_scan_ctrl
  import sevseg_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_CYCLES  = 500,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*N_DIGITS-1:0]   value_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    load,
  input  logic                    enable,
  output logic                    pending,
  output logic                    frame_start,
  output logic [6:0]              sevseg,
  output logic                    dp_n,
  output logic [N_DIGITS-1:0]     an_n
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_TH = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*N_DIGITS-1:0]   sh_val_q, sh_val_d, act_val_q, act_val_d;
  logic [N_DIGITS-1:0]     sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic                    pend_q, pend_d;
  logic                    init_q;
  logic                    fs_q;
  seg_t                    seg_q, seg_d;
  logic                    dpn_q, dpn_d;
  logic [N_DIGITS-1:0]     an_q, an_d;

  logic                    term, boundary, show;
  logic [N_DIGITS-1:0]     sup;
  logic                    zero_run;
  hex_nibble_t             sel_nib;
  seg_t                    dec_seg;

  assign term     = (cnt_q == CNT_LAST);
  assign boundary = term && (idx_q == IDX_LAST);

  always_comb begin
    cnt_d = term ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (term) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // A load coinciding with the swap lands in shadow after the old shadow moves out.
  always_comb begin
    sh_val_d  = sh_val_q;
    sh_dp_d   = sh_dp_q;
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    pend_d    = pend_q;
    if (boundary && pend_q) begin
      act_val_d = sh_val_q;
      act_dp_d  = sh_dp_q;
      pend_d    = 1'b0;
    end
    if (load) begin
      sh_val_d = value_in;
      sh_dp_d  = dp_in;
      pend_d   = 1'b1;
    end
  end

  // A digit is blanked while it and every digit above it are zero with no dp.
  always_comb begin
    sup      = '0;
    zero_run = 1'b1;
    for (int unsigned i = N_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && (act_val_q[4*i +: 4] == 4'h0);
      sup[i]   = (BLANK_LEADING != 0) && zero_run && !act_dp_q[i];
    end
  end

  assign sel_nib = act_val_q[4*idx_q +: 4];

  hex2sevseg u_dec (
    .nibble_i (sel_nib),
    .seg_o    (dec_seg)
  );

  always_comb begin
    show  = enable && (cnt_q >= BLANK_TH) && !sup[idx_q];
    an_d  = '1;
    seg_d = SEG_BLANK;
    dpn_d = 1'b1;
    if (show) begin
      an_d[idx_q] = 1'b0;
      seg_d       = dec_seg;
      dpn_d       = ~act_dp_q[idx_q];
    end
  end

  // init_q produces the frame_start pulse on the first clocked cycle out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_val_q  <= '0;
      sh_dp_q   <= '0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      pend_q    <= 1'b0;
      init_q    <= 1'b1;
      fs_q      <= 1'b0;
      seg_q     <= SEG_BLANK;
      dpn_q     <= 1'b1;
      an_q      <= '1;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_val_q  <= sh_val_d;
      sh_dp_q   <= sh_dp_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      pend_q    <= pend_d;
      init_q    <= 1'b0;
      fs_q      <= boundary || init_q;
      seg_q     <= seg_d;
      dpn_q     <= dpn_d;
      an_q      <= an_d;
    end
  end

  assign pending     = pend_q;
  assign frame_start = fs_q;
  assign sevseg      = seg_q;
  assign dp_n        = dpn_q;
  assign an_n        = an_q;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Directed bench for sevseg_scan_ctrl with 4 digits, 4-cycle slots, 1 blank cycle.
module tb_sevseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        enable;
  logic        pending;
  logic        frame_start;
  logic [6:0]  sevseg;
  logic        dp_n;
  logic [3:0]  an_n;

  int nvec = 0;
  int nmis = 0;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  lit;   // digits expected to light
    logic [27:0] seg;   // {d3,d2,d1,d0}
    logic [3:0]  dpn;   // expected dp_n per digit when lit
  } vec_t;

  vec_t tbl [7];
  vec_t rec_b, rec_c, rec_one;

  sevseg_scan_ctrl #(
    .N_DIGITS      (4),
    .REFRESH_DIV   (4),
    .BLANK_CYCLES  (1),
    .BLANK_LEADING (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value_in    (value_in),
    .dp_in       (dp_in),
    .load        (load),
    .enable      (enable),
    .pending     (pending),
    .frame_start (frame_start),
    .sevseg      (sevseg),
    .dp_n        (dp_n),
    .an_n        (an_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value_in = v;
    dp_in    = d;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // Entered on the negedge of a frame_start cycle; covers the following 16 cycles.
  task automatic check_frame(input vec_t v, input logic pend, input int dlo, input int dhi,
                             input string tag);
    int d, pos;
    logic lit;
    logic [3:0] ean;
    logic [6:0] eseg;
    logic edp;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      d    = (c - 1) / 4;
      pos  = (c - 1) % 4;
      lit  = (pos != 0) && v.lit[d] && !(c >= dlo && c <= dhi);
      ean  = lit ? ~(4'b0001 << d) : 4'hF;
      eseg = lit ? v.seg[d*7 +: 7] : 7'h7F;
      edp  = lit ? v.dpn[d] : 1'b1;
      chk($sformatf("%s pins c%0d", tag, c), {20'd0, ean, eseg, edp}, {20'd0, an_n, sevseg, dp_n});
      chk($sformatf("%s frame_start c%0d", tag, c), {31'd0, frame_start}, {31'd0, (c == 16)});
      if (c < 16) chk($sformatf("%s pending c%0d", tag, c), {31'd0, pending}, {31'd0, pend});
    end
  endtask

  // Entered on the negedge where rst is released; active value is zero.
  task automatic post_reset_check(input string tag);
    logic [3:0] ean;
    logic [6:0] eseg;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      ean  = (c >= 2 && c <= 4) ? 4'b1110 : 4'hF;
      eseg = (c >= 2 && c <= 4) ? 7'h40 : 7'h7F;
      chk($sformatf("%s pins c%0d", tag, c), {20'd0, an_n, sevseg, dp_n}, {20'd0, ean, eseg, 1'b1});
      chk($sformatf("%s frame_start c%0d", tag, c), {31'd0, frame_start}, {31'd0, (c == 1)});
      chk($sformatf("%s pending c%0d", tag, c), {31'd0, pending}, 32'd0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " an_n"}, {28'd0, an_n}, 32'hF);
    chk({tag, " sevseg"}, {25'd0, sevseg}, 32'h7F);
    chk({tag, " dp_n"}, {31'd0, dp_n}, 32'd1);
    chk({tag, " pending"}, {31'd0, pending}, 32'd0);
    chk({tag, " frame_start"}, {31'd0, frame_start}, 32'd0);
  endtask

  initial begin
    tbl[0] = '{16'h1234, 4'b0000, 4'b1111, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
    tbl[1] = '{16'h0050, 4'b0000, 4'b0011, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
    tbl[2] = '{16'h0000, 4'b0100, 4'b0101, {7'h7F, 7'h40, 7'h7F, 7'h40}, 4'b1011};
    tbl[3] = '{16'h0800, 4'b1000, 4'b1111, {7'h40, 7'h00, 7'h40, 7'h40}, 4'b0111};
    tbl[4] = '{16'h9ACF, 4'b0011, 4'b1111, {7'h10, 7'h08, 7'h46, 7'h0E}, 4'b1100};
    tbl[5] = '{16'h000E, 4'b0000, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h06}, 4'b1111};
    tbl[6] = '{16'h0100, 4'b0001, 4'b0111, {7'h7F, 7'h79, 7'h40, 7'h40}, 4'b1110};
    rec_b   = '{16'hBBBB, 4'b0000, 4'b1111, {4{7'h03}}, 4'b1111};
    rec_c   = '{16'hCCCC, 4'b0000, 4'b1111, {4{7'h46}}, 4'b1111};
    rec_one = '{16'h1111, 4'b0000, 4'b1111, {4{7'h79}}, 4'b1111};

    rst = 1'b1; value_in = '0; dp_in = '0; load = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    post_reset_check("initial");

    begin : sync
      bit seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
        @(negedge clk);
        if (frame_start) seen = 1'b1;
      end
      if (!seen) begin
        nvec++; nmis++;
        $display("FAIL frame_start timeout: got none expected pulse within 64 cycles");
      end
    end

    for (int i = 0; i < 7; i++) begin
      do_load(tbl[i].val, tbl[i].dp);
      chk($sformatf("vec%0d pending after load", i), {31'd0, pending}, 32'd1);
      repeat (15) @(negedge clk);
      chk($sformatf("vec%0d frame_start", i), {31'd0, frame_start}, 32'd1);
      check_frame(tbl[i], 1'b0, 0, -1, $sformatf("vec%0d", i));
    end

    // Two loads within one frame: only the last is shown.
    do_load(16'hAAAA, 4'b0000);
    do_load(16'hBBBB, 4'b0000);
    repeat (14) @(negedge clk);
    check_frame(rec_b, 1'b0, 0, -1, "lastwins");

    // Load on the exact boundary cycle: old shadow shown, new one a frame later.
    do_load(16'hCCCC, 4'b0000);
    repeat (14) @(negedge clk);
    do_load(16'h1111, 4'b0000);
    chk("bnd frame_start", {31'd0, frame_start}, 32'd1);
    chk("bnd pending", {31'd0, pending}, 32'd1);
    check_frame(rec_c, 1'b1, 0, -1, "bnd_old");
    check_frame(rec_one, 1'b0, 0, -1, "bnd_new");

    // enable low for 6 cycles mid-frame.
    fork
      check_frame(rec_one, 1'b0, 6, 11, "enable");
      begin
        repeat (5) @(negedge clk);
        enable = 1'b0;
        repeat (6) @(negedge clk);
        enable = 1'b1;
      end
    join

    // Reset mid-slot with a pending value.
    do_load(16'h4321, 4'b0000);
    repeat (5) @(negedge clk);
    chk("pre-rst pending", {31'd0, pending}, 32'd1);
    chk("pre-rst an_n", {28'd0, an_n}, 32'hD);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    post_reset_check("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
